// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor pipeline companion.
// Holds the default sizing parameters, the predictor's outcome encoding, and
// a saturating-increment helper used by the statistics counters.
package bp_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // Predictor outcome encoding
  localparam logic PRED_TAKEN     = 1'b1;
  localparam logic PRED_NOT_TAKEN = 1'b0;

  // Increment val, holding at the all-ones value of a width-bit counter.
  // Works on a 32-bit carrier; callers truncate to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bp_fifo.sv
// 1-bit-wide synchronous FIFO holding in-flight branch predictions.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_data    write one prediction at the tail
//   pop                drop the head entry
//   head               current head value (valid when !empty)
//   count              number of stored entries (0..DEPTH)
//   full, empty        status flags
// Push and pop in the same cycle are both honoured, including when full.
module bp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          push_data,
  input  logic          pop,
  output logic          head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Pipeline-side companion to the 2-bit saturating-counter branch predictor.
// Issues predictor lookups for fetched branches, queues the returned
// predictions in order, and on each resolve compares the oldest prediction
// with the real outcome, trains the predictor and keeps accuracy statistics.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   br_fetch / fetch_ready     fetch offers a branch / one may be accepted
//   br_resolve, br_taken       execute resolves the oldest branch, real outcome
//   pred_request               predictor lookup (same cycle as accept)
//   pred_prediction            predictor answer, valid the cycle after request
//   pred_result, pred_taken    predictor training strobe and outcome
//   mispredict, pred_out       registered result of the branch just resolved
//   resolve_err                sticky: resolve with nothing in flight
//   total_cnt, miss_cnt        saturating statistics
module branch_resolver
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_fetch,
  output logic             fetch_ready,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             pred_request,
  input  logic             pred_prediction,
  output logic             pred_result,
  output logic             pred_taken,
  output logic             mispredict,
  output logic             pred_out,
  output logic             resolve_err,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic             pend_q, pend_d;
  logic             mispredict_q, mispredict_d;
  logic             pred_out_q, pred_out_d;
  logic             resolve_err_q, resolve_err_d;
  logic [CNT_W-1:0] total_q, total_d, miss_q, miss_d;
  logic [31:0]      total_inc, miss_inc;

  logic        fifo_head, fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [AW:0] fifo_count;
  logic [AW:0] occ;
  logic        accept, res_valid, use_bypass, pred_sel;

  // In-flight branches: captured entries plus the one awaiting its prediction
  assign occ        = fifo_count + (AW + 1)'(pend_q);
  assign res_valid  = br_resolve & (occ != '0);
  // At full occupancy a resolve frees a slot in the same cycle
  assign fetch_ready = (occ != FULL_CNT) | br_resolve;
  assign accept      = br_fetch & fetch_ready;
  // Empty FIFO with something in flight means the pending lookup is the oldest
  assign use_bypass  = res_valid & fifo_empty;
  assign pred_sel    = fifo_empty ? pred_prediction : fifo_head;

  assign fifo_pop  = res_valid & ~fifo_empty;
  assign fifo_push = pend_q & ~use_bypass;

  assign pred_request = accept;
  assign pred_result  = res_valid;
  assign pred_taken   = res_valid ? br_taken : PRED_NOT_TAKEN;

  bp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (pred_prediction),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign total_inc = sat_inc(32'(total_q), CNT_W);
  assign miss_inc  = sat_inc(32'(miss_q), CNT_W);

  always_comb begin
    pend_d        = accept;
    mispredict_d  = 1'b0;
    pred_out_d    = pred_out_q;
    resolve_err_d = resolve_err_q;
    total_d       = total_q;
    miss_d        = miss_q;
    if (res_valid) begin
      mispredict_d = (pred_sel != br_taken);
      pred_out_d   = pred_sel;
      total_d      = total_inc[CNT_W-1:0];
      if (pred_sel != br_taken) begin
        miss_d = miss_inc[CNT_W-1:0];
      end
    end else if (br_resolve) begin
      resolve_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= 1'b0;
      mispredict_q  <= 1'b0;
      pred_out_q    <= 1'b0;
      resolve_err_q <= 1'b0;
      total_q       <= '0;
      miss_q        <= '0;
    end else begin
      pend_q        <= pend_d;
      mispredict_q  <= mispredict_d;
      pred_out_q    <= pred_out_d;
      resolve_err_q <= resolve_err_d;
      total_q       <= total_d;
      miss_q        <= miss_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign pred_out    = pred_out_q;
  assign resolve_err = resolve_err_q;
  assign total_cnt   = total_q;
  assign miss_cnt    = miss_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
